minterm_scanner: RTL and testbench

Self-checking truth-table scanner for a 4-input combinational function block. It drives every input vector 0..15 onto the function under test and waits a programmable settle time per vector. It then samples the single-bit function output and accumulates a 16-bit truth table. When the sweep is complete it compares the table against a parameterised minterm mask and reports the match result, the mismatch count and the lowest failing minterm. It sits in the project's on-chip check path, on the receiving end of the function block's output.

---
 rtl/scan_pkg.sv | 21 ++
 rtl/scan_settle_timer.sv | 60 ++++++
 rtl/minterm_scanner.sv | 219 +++++++++++++++++++++
 tb/tb_minterm_scanner.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// -----------------------------------------------------------------------------
// scan_pkg
// Shared definitions for the minterm truth-table scanner:
//   - scan_state_e    : scanner FSM states
//   - F_MASK_DEFAULT  : default expected minterm mask, m(0,1,8,9,10,11,12,14,15)
//   - SETTLE_DEFAULT  : default number of cycles each vector is held
// No ports (package).
// -----------------------------------------------------------------------------
package scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } scan_state_e;

    localparam logic [15:0] F_MASK_DEFAULT = 16'hDF03;
    localparam int          SETTLE_DEFAULT = 2;

endpackage : scan_pkg

// File: rtl/scan_settle_timer.sv
// -----------------------------------------------------------------------------
// scan_settle_timer
// Load/count/terminal-flag counter that measures how long a vector has been
// held in DRIVE. The terminal flag is registered and is high while the count
// equals SETTLE-1, i.e. during the last DRIVE cycle of a vector.
// Ports:
//   clk     in  : clock, rising edge
//   rst     in  : synchronous active-high reset
//   load_i  in  : restart the count at zero (has priority over en_i)
//   en_i    in  : advance the count by one
//   term_o  out : count has reached SETTLE-1
// -----------------------------------------------------------------------------
module scan_settle_timer #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic term_o
);

    localparam int             CW     = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [CW-1:0]  TERM   = CW'(SETTLE - 1);
    localparam logic [CW-1:0]  ZERO   = CW'(0);
    localparam logic [CW-1:0]  ONE    = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          term_q;
    logic          term_d;

    // Next count: load wins, the count stops at the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = ZERO;
        end else if (en_i && !term_q) begin
            cnt_d = cnt_q + ONE;
        end else begin
            cnt_d = cnt_q;
        end
        // Registering the decode of the next count keeps term aligned with cnt_q.
        term_d = (cnt_d == TERM);
    end

    // Counter and terminal-flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= ZERO;
            term_q <= (ZERO == TERM);
        end else begin
            cnt_q  <= cnt_d;
            term_q <= term_d;
        end
    end

    assign term_o = term_q;

endmodule : scan_settle_timer

// File: rtl/minterm_scanner.sv
// -----------------------------------------------------------------------------
// minterm_scanner
// Sweeps every input vector 0..2^N_IN-1 onto a combinational function block,
// holds each vector SETTLE cycles, samples the function output once, builds
// the truth table and compares it against EXPECTED.
// Ports:
//   clk          in  : clock, rising edge
//   rst          in  : synchronous active-high reset
//   start        in  : scan request, honoured only in IDLE
//   f_in         in  : output of the function under test
//   vec_out      out : vector driven to the function, {W,X,Y,Z}
//   busy         out : scan in progress (through the DONE cycle)
//   done         out : one-cycle result-valid pulse
//   truth        out : captured truth table, bit i = F(i)
//   match        out : truth == EXPECTED
//   mismatch_cnt out : popcount(truth ^ EXPECTED)
//   first_fail   out : lowest failing minterm index
//   fail_valid   out : at least one minterm failed
// -----------------------------------------------------------------------------
module minterm_scanner
    import scan_pkg::*;
#(
    parameter int                    N_IN     = 4,
    parameter logic [(1<<N_IN)-1:0]  EXPECTED = F_MASK_DEFAULT,
    parameter int                    SETTLE   = SETTLE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 f_in,
    output logic [N_IN-1:0]      vec_out,
    output logic                 busy,
    output logic                 done,
    output logic [(1<<N_IN)-1:0] truth,
    output logic                 match,
    output logic [N_IN:0]        mismatch_cnt,
    output logic [N_IN-1:0]      first_fail,
    output logic                 fail_valid
);

    localparam int               TW       = 1 << N_IN;
    localparam logic [N_IN-1:0]  VEC_ZERO = N_IN'(0);
    localparam logic [N_IN-1:0]  VEC_ONE  = N_IN'(1);
    localparam logic [N_IN-1:0]  VEC_LAST = {N_IN{1'b1}};
    localparam logic [N_IN:0]    CNT_ZERO = (N_IN + 1)'(0);
    localparam logic [N_IN:0]    CNT_ONE  = (N_IN + 1)'(1);
    localparam logic [TW-1:0]    TT_ZERO  = TW'(0);

    scan_state_e        state_q, state_d;
    logic [N_IN-1:0]    vec_out_q, vec_out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [TW-1:0]      truth_q, truth_d;
    logic               match_q, match_d;
    logic [N_IN:0]      mismatch_cnt_q, mismatch_cnt_d;
    logic [N_IN-1:0]    first_fail_q, first_fail_d;
    logic               fail_valid_q, fail_valid_d;

    logic               tmr_load_s;
    logic               tmr_en_s;
    logic               tmr_term_s;
    logic               is_last_s;
    logic               miss_s;

    assign is_last_s = (vec_out_q == VEC_LAST);
    assign miss_s    = (f_in != EXPECTED[vec_out_q]);

    scan_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (tmr_load_s),
        .en_i   (tmr_en_s),
        .term_o (tmr_term_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_DRIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (tmr_term_s) begin
                    state_d = ST_SAMPLE;
                end else begin
                    state_d = ST_DRIVE;
                end
            end
            ST_SAMPLE: begin
                if (is_last_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRIVE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM output logic: next values of all registered outputs plus timer control.
    always_comb begin
        vec_out_d      = vec_out_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        truth_d        = truth_q;
        match_d        = match_q;
        mismatch_cnt_d = mismatch_cnt_q;
        first_fail_d   = first_fail_q;
        fail_valid_d   = fail_valid_q;
        tmr_load_s     = 1'b0;
        tmr_en_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                vec_out_d = VEC_ZERO;
                if (start) begin
                    // Accepted start: previous results are discarded here, not earlier.
                    busy_d         = 1'b1;
                    truth_d        = TT_ZERO;
                    match_d        = 1'b0;
                    mismatch_cnt_d = CNT_ZERO;
                    first_fail_d   = VEC_ZERO;
                    fail_valid_d   = 1'b0;
                    tmr_load_s     = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_DRIVE: begin
                busy_d   = 1'b1;
                tmr_en_s = 1'b1;
            end
            ST_SAMPLE: begin
                busy_d             = 1'b1;
                truth_d[vec_out_q] = f_in;
                if (miss_s) begin
                    mismatch_cnt_d = mismatch_cnt_q + CNT_ONE;
                    if (!fail_valid_q) begin
                        first_fail_d = vec_out_q;
                        fail_valid_d = 1'b1;
                    end else begin
                        first_fail_d = first_fail_q;
                    end
                end else begin
                    mismatch_cnt_d = mismatch_cnt_q;
                end
                if (is_last_s) begin
                    // Final sample: results must already be complete in the done cycle.
                    done_d  = 1'b1;
                    match_d = (mismatch_cnt_q == CNT_ZERO) && !miss_s;
                end else begin
                    vec_out_d  = vec_out_q + VEC_ONE;
                    tmr_load_s = 1'b1;
                end
            end
            ST_DONE: begin
                busy_d    = 1'b0;
                vec_out_d = VEC_ZERO;
            end
            default: begin
                busy_d    = 1'b0;
                vec_out_d = VEC_ZERO;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_out_q      <= VEC_ZERO;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            truth_q        <= TT_ZERO;
            match_q        <= 1'b0;
            mismatch_cnt_q <= CNT_ZERO;
            first_fail_q   <= VEC_ZERO;
            fail_valid_q   <= 1'b0;
        end else begin
            vec_out_q      <= vec_out_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            truth_q        <= truth_d;
            match_q        <= match_d;
            mismatch_cnt_q <= mismatch_cnt_d;
            first_fail_q   <= first_fail_d;
            fail_valid_q   <= fail_valid_d;
        end
    end

    assign vec_out      = vec_out_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign truth        = truth_q;
    assign match        = match_q;
    assign mismatch_cnt = mismatch_cnt_q;
    assign first_fail   = first_fail_q;
    assign fail_valid   = fail_valid_q;

endmodule : minterm_scanner

// File: tb/tb_minterm_scanner.sv
// -----------------------------------------------------------------------------
// tb_minterm_scanner
// Directed bench for minterm_scanner with default parameters. The function
// under test is modelled from a hand-written minterm list in several variants
// (golden, stuck-at-0, minterm 13 forced high, inverted).
// -----------------------------------------------------------------------------
module tb_minterm_scanner;

    logic        clk;
    logic        rst;
    logic        start;
    logic        f_in;
    logic [3:0]  vec_out;
    logic        busy;
    logic        done;
    logic [15:0] truth;
    logic        match;
    logic [4:0]  mismatch_cnt;
    logic [3:0]  first_fail;
    logic        fail_valid;

    int n_vec;
    int n_err;
    int mode;

    // F(W,X,Y,Z) = m(0,1,8,9,10,11,12,14,15)
    logic [15:0] gold;
    assign gold = 16'b1101_1111_0000_0011;

    minterm_scanner dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .f_in         (f_in),
        .vec_out      (vec_out),
        .busy         (busy),
        .done         (done),
        .truth        (truth),
        .match        (match),
        .mismatch_cnt (mismatch_cnt),
        .first_fail   (first_fail),
        .fail_valid   (fail_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Function-under-test model, selected by mode.
    always_comb begin
        case (mode)
            0:       f_in = gold[vec_out];
            1:       f_in = 1'b0;
            2:       f_in = (vec_out == 4'd13) ? 1'b1 : gold[vec_out];
            3:       f_in = ~gold[vec_out];
            default: f_in = 1'b0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one full scan; checks latency, vec_out windows, results and hold.
    task automatic run_scan(input int md, input logic [15:0] e_truth, input logic e_match,
                            input int e_mm, input int e_ff, input logic e_fv,
                            input logic repulse);
        int cyc;
        int run;
        int ndone;
        logic [3:0] prev;
        mode  = md;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("done_after_start", {31'd0, done}, 32'd0);
        prev = vec_out;
        run  = 1;
        cyc  = 0;
        while (cyc < 200) begin
            start = (repulse && (cyc == 5 || cyc == 30)) ? 1'b1 : 1'b0;
            tick();
            start = 1'b0;
            cyc++;
            if (done) break;
            if (vec_out !== prev) begin
                chk("vec_window", run, 32'd3);
                chk("vec_step", {28'd0, vec_out}, {28'd0, prev + 4'd1});
                prev = vec_out;
                run  = 1;
            end else begin
                run++;
            end
        end
        chk("done_latency", cyc, 32'd48);
        chk("last_window", run, 32'd3);
        chk("last_vec", {28'd0, prev}, 32'd15);
        chk("busy_in_done", {31'd0, busy}, 32'd1);
        chk("truth", {16'd0, truth}, {16'd0, e_truth});
        chk("match", {31'd0, match}, {31'd0, e_match});
        chk("mismatch_cnt", {27'd0, mismatch_cnt}, e_mm);
        chk("first_fail", {28'd0, first_fail}, e_ff);
        chk("fail_valid", {31'd0, fail_valid}, {31'd0, e_fv});
        // Pulse width, return to idle and result hold.
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) ndone++;
        end
        chk("done_single", ndone, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("vec_idle", {28'd0, vec_out}, 32'd0);
        chk("truth_hold", {16'd0, truth}, {16'd0, e_truth});
        chk("mm_hold", {27'd0, mismatch_cnt}, e_mm);
    endtask

    initial begin
        int ndone;
        n_vec = 0;
        n_err = 0;
        mode  = 0;
        rst   = 1'b1;
        start = 1'b0;
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_vec", {28'd0, vec_out}, 32'd0);
        chk("rst_truth", {16'd0, truth}, 32'd0);
        chk("rst_match", {31'd0, match}, 32'd0);
        chk("rst_mm", {27'd0, mismatch_cnt}, 32'd0);
        chk("rst_ff", {28'd0, first_fail}, 32'd0);
        chk("rst_fv", {31'd0, fail_valid}, 32'd0);

        // rst and start together: reset wins.
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        tick();
        chk("rst_start_busy", {31'd0, busy}, 32'd0);

        run_scan(0, 16'hDF03, 1'b1, 0, 0, 1'b0, 1'b0);
        run_scan(1, 16'h0000, 1'b0, 9, 0, 1'b1, 1'b0);
        run_scan(2, 16'hFF03, 1'b0, 1, 13, 1'b1, 1'b0);
        run_scan(3, 16'h20FC, 1'b0, 16, 0, 1'b1, 1'b0);

        // Reset mid-scan discards partial results and never produces done.
        mode  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_vec", {28'd0, vec_out}, 32'd0);
        chk("mid_rst_truth", {16'd0, truth}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        ndone = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (done) ndone++;
        end
        chk("mid_rst_no_done", ndone, 32'd0);

        run_scan(0, 16'hDF03, 1'b1, 0, 0, 1'b0, 1'b0);
        // start re-pulsed during the scan is ignored.
        run_scan(2, 16'hFF03, 1'b0, 1, 13, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_minterm_scanner
